// File: rtl/aes_pkg.sv
// Shared AES constants and the round_key_store FSM encoding.
//   AES_NUM_ROUND_KEYS : round keys per AES-256 schedule (15)
//   AES_KEY_W          : round-key width in bits (128)
//   AES_IDX_W          : width of a round index (4)
//   IDLE/LOAD/READY/STREAM : 2-bit state codes of round_key_store
package aes_pkg;

  localparam int AES_NUM_ROUND_KEYS = 15;
  localparam int AES_KEY_W          = 128;
  localparam int AES_IDX_W          = 4;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LOAD   = 2'd1;
  localparam logic [1:0] READY  = 2'd2;
  localparam logic [1:0] STREAM = 2'd3;

endpackage

// File: rtl/rk_regfile.sv
// Round-key storage: DEPTH x W words, one synchronous write port and one
// registered read port. The read register is reset so the key output of
// the parent block reads zero out of reset; the array itself is not reset.
// Ports:
//   clk, rst      : clock, async active-low reset (read register only)
//   we/waddr/wdata: write port
//   re/raddr      : read request; rdata updates on the edge where re=1
//   rdata         : registered read data, held while re=0
module rk_regfile #(
  parameter int DEPTH = 15,
  parameter int W     = 128,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  logic [W-1:0] mem [DEPTH];

  // Storage array write; addresses beyond the last entry are dropped.
  always_ff @(posedge clk) begin
    if (we && (waddr <= LAST_ADDR)) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read port; holds its value when no read is requested.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata <= '0;
    end else if (re) begin
      if (raddr <= LAST_ADDR) begin
        rdata <= mem[raddr];
      end else begin
        rdata <= '0;
      end
    end else begin
      rdata <= rdata;
    end
  end

endmodule

// File: rtl/round_key_store.sv
// Captures the 15 AES-256 round keys streamed by key expansion and
// replays them over valid/ready, forward (0..14) or reverse (14..0).
// Ports:
//   clk, rst            : clock, async active-low reset
//   load_start          : clear the store and capture a new key set
//   in_valid, in_key    : incoming round keys, in round order
//   rd_start, rd_dir    : start a replay; rd_dir 0 = forward, 1 = reverse
//   out_ready           : downstream accepts the presented key
//   out_valid, out_key,
//   out_round, out_last : presented key, its round index, final-key flag
//   keys_ready          : a full key set is stored
//   busy                : loading or streaming
module round_key_store
  import aes_pkg::*;
#(
  parameter int NUM_KEYS = AES_NUM_ROUND_KEYS,
  parameter int KEY_W    = AES_KEY_W,
  parameter int IDX_W    = AES_IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_start,
  input  logic             in_valid,
  input  logic [KEY_W-1:0] in_key,
  input  logic             rd_start,
  input  logic             rd_dir,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [KEY_W-1:0] out_key,
  output logic [IDX_W-1:0] out_round,
  output logic             out_last,
  output logic             keys_ready,
  output logic             busy
);

  localparam logic [IDX_W-1:0] FIRST_IDX = '0;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_KEYS - 1);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [IDX_W-1:0] wr_cnt;
  logic [IDX_W-1:0] rd_idx;
  logic             dir;
  logic             dir_eff;
  logic             we;
  logic             re;
  logic [IDX_W-1:0] raddr;
  logic             last_nxt;
  logic             hs;

  assign hs = out_valid & out_ready;

  // Next-state decode plus the write/read requests for the register file.
  // load_start has top priority in every state except IDLE, where it is
  // the only input that matters anyway.
  always_comb begin
    state_nxt = state;
    we        = 1'b0;
    re        = 1'b0;
    raddr     = rd_idx;
    dir_eff   = dir;
    case (state)
      IDLE: begin
        if (load_start) begin
          state_nxt = LOAD;
        end else begin
          state_nxt = IDLE;
        end
      end
      LOAD: begin
        if (load_start) begin
          state_nxt = LOAD;
        end else if (in_valid) begin
          we = 1'b1;
          if (wr_cnt == LAST_IDX) begin
            state_nxt = READY;
          end else begin
            state_nxt = LOAD;
          end
        end else begin
          state_nxt = LOAD;
        end
      end
      READY: begin
        if (load_start) begin
          state_nxt = LOAD;
        end else if (rd_start) begin
          state_nxt = STREAM;
          re        = 1'b1;
          dir_eff   = rd_dir;
          if (rd_dir) begin
            raddr = LAST_IDX;
          end else begin
            raddr = FIRST_IDX;
          end
        end else begin
          state_nxt = READY;
        end
      end
      STREAM: begin
        if (load_start) begin
          state_nxt = LOAD;
        end else if (hs) begin
          if (out_last) begin
            state_nxt = READY;
          end else begin
            // out_last guards the terminal index, so the step below
            // never leaves the 0..NUM_KEYS-1 range.
            state_nxt = STREAM;
            re        = 1'b1;
            if (dir) begin
              raddr = rd_idx - IDX_W'(1);
            end else begin
              raddr = rd_idx + IDX_W'(1);
            end
          end
        end else begin
          state_nxt = STREAM;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Final index of a replay: 0 when reversing, NUM_KEYS-1 when forward.
  always_comb begin
    if (dir_eff) begin
      last_nxt = (raddr == FIRST_IDX);
    end else begin
      last_nxt = (raddr == LAST_IDX);
    end
  end

  // FSM state, counters and registered status/handshake outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      wr_cnt     <= '0;
      rd_idx     <= '0;
      dir        <= 1'b0;
      out_valid  <= 1'b0;
      out_round  <= '0;
      out_last   <= 1'b0;
      keys_ready <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      out_valid  <= (state_nxt == STREAM);
      keys_ready <= (state_nxt == READY) || (state_nxt == STREAM);
      busy       <= (state_nxt == LOAD) || (state_nxt == STREAM);

      // Write counter saturates at the last index; the FSM leaves LOAD there.
      if (load_start && (state != IDLE || state_nxt == LOAD)) begin
        wr_cnt <= '0;
      end else if (we && (wr_cnt != LAST_IDX)) begin
        wr_cnt <= wr_cnt + IDX_W'(1);
      end else begin
        wr_cnt <= wr_cnt;
      end

      if (re) begin
        rd_idx    <= raddr;
        dir       <= dir_eff;
        out_round <= raddr;
        out_last  <= last_nxt;
      end else if (state_nxt != STREAM) begin
        out_last  <= 1'b0;
      end else begin
        out_last  <= out_last;
      end
    end
  end

  rk_regfile #(
    .DEPTH (NUM_KEYS),
    .W     (KEY_W),
    .AW    (IDX_W)
  ) u_regfile (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .waddr (wr_cnt),
    .wdata (in_key),
    .re    (re),
    .raddr (raddr),
    .rdata (out_key)
  );

endmodule

// File: tb/tb_round_key_store.sv
// Scoreboard bench for round_key_store: stimulus pushes expected beats
// into a queue, an independent negedge monitor pops and compares them.
module tb_round_key_store;
  import aes_pkg::*;

  logic         clk;
  logic         rst;
  logic         load_start;
  logic         in_valid;
  logic [127:0] in_key;
  logic         rd_start;
  logic         rd_dir;
  logic         out_ready;
  logic         out_valid;
  logic [127:0] out_key;
  logic [3:0]   out_round;
  logic         out_last;
  logic         keys_ready;
  logic         busy;

  round_key_store dut (
    .clk        (clk),
    .rst        (rst),
    .load_start (load_start),
    .in_valid   (in_valid),
    .in_key     (in_key),
    .rd_start   (rd_start),
    .rd_dir     (rd_dir),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_key    (out_key),
    .out_round  (out_round),
    .out_last   (out_last),
    .keys_ready (keys_ready),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [127:0] key;
    logic [3:0]   rnd;
    logic         last;
  } exp_t;

  exp_t         q[$];
  int           total = 0;
  int           bad   = 0;
  logic [127:0] cur_keys [15];
  logic [127:0] exp_keys [15];
  logic [7:0]   sbox_tab [256];
  logic [2047:0] sbox_flat;

  logic         held_vld = 1'b0;
  exp_t         held;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp_v);
    end
  endtask

  // Monitor: checks hold-stability after a stall and pops on each handshake.
  always @(negedge clk) begin
    if (rst) begin
      if (held_vld) begin
        chk("hold_valid", {127'd0, out_valid}, 128'd1);
        chk("hold_key", out_key, held.key);
        chk("hold_round", {124'd0, out_round}, {124'd0, held.rnd});
        chk("hold_last", {127'd0, out_last}, {127'd0, held.last});
      end
      held_vld = 1'b0;
      if (out_valid) begin
        if (out_ready) begin
          if (q.size() == 0) begin
            chk("unexpected_beat", {127'd0, out_valid}, 128'd0);
          end else begin
            exp_t e;
            e = q.pop_front();
            chk("beat_key", out_key, e.key);
            chk("beat_round", {124'd0, out_round}, {124'd0, e.rnd});
            chk("beat_last", {127'd0, out_last}, {127'd0, e.last});
          end
        end else begin
          held_vld = 1'b1;
          held     = '{key: out_key, rnd: out_round, last: out_last};
        end
      end
    end
  end

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sbox_tab[x[31:24]], sbox_tab[x[23:16]], sbox_tab[x[15:8]], sbox_tab[x[7:0]]};
  endfunction

  // AES-256 key expansion into cur_keys.
  task automatic expand_key(input logic [255:0] key);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0) begin
        t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0};
      end else if (i % 8 == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-8] ^ t;
    end
    for (int r = 0; r < 15; r++) cur_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_set(input int n);
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_key   = cur_keys[i];
      tick();
    end
    in_valid = 1'b0;
    in_key   = 128'd0;
  endtask

  // Replay with expected beats queued; abort_at>=0 raises load_start on that beat.
  task automatic replay(input logic dir, input logic toggle, input int abort_at, output int cycles);
    int nexp;
    bit done;
    nexp = (abort_at >= 0) ? abort_at + 1 : 15;
    for (int k = 0; k < nexp; k++) begin
      logic [3:0] r;
      r = dir ? 4'(14 - k) : 4'(k);
      q.push_back('{key: exp_keys[r], rnd: r, last: (dir ? (r == 4'd0) : (r == 4'd14))});
    end
    rd_start  = 1'b1;
    rd_dir    = dir;
    out_ready = 1'b1;
    tick();
    rd_start = 1'b0;
    chk("first_latency", {127'd0, out_valid}, 128'd1);
    done   = 1'b0;
    cycles = 0;
    for (int c = 0; c < 100; c++) begin
      out_ready  = toggle ? (c % 2 == 0) : 1'b1;
      load_start = (c == abort_at);
      @(negedge clk);
      #1;
      cycles = c + 1;
      if (q.size() == 0) begin
        done = 1'b1;
        break;
      end
      tick();
    end
    if (!done) chk("replay_timeout", 128'd0, 128'd1);
    tick();
    load_start = 1'b0;
    out_ready  = 1'b0;
  endtask

  initial begin
    int cyc;
    sbox_flat = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb8145ede0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
    for (int i = 0; i < 256; i++) sbox_tab[i] = sbox_flat[2047-8*i -: 8];

    cur_keys[0]  = 128'h000102030405060708090a0b0c0d0e0f;
    cur_keys[1]  = 128'h101112131415161718191a1b1c1d1e1f;
    cur_keys[2]  = 128'ha573c29fa176c498a97fce93a572c09c;
    cur_keys[3]  = 128'h1651a8cd0244beda1a5da4c10640bade;
    cur_keys[4]  = 128'hae87dff00ff11b68a68ed5fb03fc1567;
    cur_keys[5]  = 128'h6de1f1486fa54f9275f8eb5373b8518d;
    cur_keys[6]  = 128'hc656827fc9a799176f294cec6cd5598b;
    cur_keys[7]  = 128'h3de23a75524775e727bf9eb45407cf39;
    cur_keys[8]  = 128'h0bdc905fc27b0948ad5245a4c1871c2f;
    cur_keys[9]  = 128'h45f5a66017b2d387300d4d33640a820a;
    cur_keys[10] = 128'h7ccff71cbeb4fe5413e6bbf0d261a7df;
    cur_keys[11] = 128'hf01afafee7a82979d7a5644ab3afe640;
    cur_keys[12] = 128'h2541fe719bf500258813bbd55a721c0a;
    cur_keys[13] = 128'h4e5a6699a9f24fe07e572baacdf8cdea;
    cur_keys[14] = 128'h24fc79ccbf0979e9371ac23c6d68de36;
    exp_keys = cur_keys;

    rst = 1'b0; load_start = 1'b0; in_valid = 1'b0; in_key = 128'd0;
    rd_start = 1'b0; rd_dir = 1'b0; out_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {127'd0, out_valid}, 128'd0);
    chk("rst_key", out_key, 128'd0);
    chk("rst_round", {124'd0, out_round}, 128'd0);
    chk("rst_last", {127'd0, out_last}, 128'd0);
    chk("rst_keys_ready", {127'd0, keys_ready}, 128'd0);
    chk("rst_busy", {127'd0, busy}, 128'd0);
    chk("rst_state", {126'd0, dut.state}, {126'd0, IDLE});
    rst = 1'b1;
    tick();

    // IDLE ignores rd_start and in_valid
    rd_start = 1'b1; in_valid = 1'b1;
    tick();
    rd_start = 1'b0; in_valid = 1'b0;
    chk("idle_ignore", {126'd0, dut.state}, {126'd0, IDLE});

    // Load FIPS-197 schedule, forward replay at full rate
    load_set(15);
    chk("loaded_keys_ready", {127'd0, keys_ready}, 128'd1);
    chk("loaded_busy", {127'd0, busy}, 128'd0);
    replay(1'b0, 1'b0, -1, cyc);
    chk("fwd_cycles", 128'(cyc), 128'd15);
    chk("fwd_done_valid", {127'd0, out_valid}, 128'd0);
    chk("fwd_done_state", {126'd0, dut.state}, {126'd0, READY});

    // Reverse replay with back-pressure 1,0,1,0...
    replay(1'b1, 1'b1, -1, cyc);
    chk("rev_cycles", 128'(cyc), 128'd29);
    chk("rev_done_state", {126'd0, dut.state}, {126'd0, READY});
    chk("rev_keys_ready", {127'd0, keys_ready}, 128'd1);

    // Second key set from expansion; rounds 0/1 checked against hand values
    expand_key(256'h642423baa95efb4362d3f2ce993c0904150f258aa1fe796841d7b4429c9b5a30);
    exp_keys    = cur_keys;
    exp_keys[0] = 128'h642423baa95efb4362d3f2ce993c0904;
    exp_keys[1] = 128'h150f258aa1fe796841d7b4429c9b5a30;
    load_set(15);
    replay(1'b0, 1'b0, -1, cyc);
    chk("setb_cycles", 128'(cyc), 128'd15);

    // Abort on the 5th beat
    replay(1'b0, 1'b0, 4, cyc);
    chk("abort_valid", {127'd0, out_valid}, 128'd0);
    chk("abort_last", {127'd0, out_last}, 128'd0);
    chk("abort_keys_ready", {127'd0, keys_ready}, 128'd0);
    chk("abort_busy", {127'd0, busy}, 128'd1);
    chk("abort_state", {126'd0, dut.state}, {126'd0, LOAD});

    // Partial load of 10 beats: not ready, rd_start ignored
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_key   = cur_keys[i];
      tick();
    end
    in_valid = 1'b0;
    chk("partial_keys_ready", {127'd0, keys_ready}, 128'd0);
    rd_start = 1'b1; rd_dir = 1'b0;
    tick();
    rd_start = 1'b0;
    chk("partial_rd_valid", {127'd0, out_valid}, 128'd0);
    chk("partial_state", {126'd0, dut.state}, {126'd0, LOAD});

    // load_start and rd_start together in READY: load wins
    load_set(15);
    chk("coll_pre_ready", {127'd0, keys_ready}, 128'd1);
    load_start = 1'b1; rd_start = 1'b1;
    tick();
    load_start = 1'b0; rd_start = 1'b0;
    chk("coll_state", {126'd0, dut.state}, {126'd0, LOAD});
    chk("coll_keys_ready", {127'd0, keys_ready}, 128'd0);
    tick();
    chk("coll_valid", {127'd0, out_valid}, 128'd0);

    // Async reset mid-stream
    load_set(15);
    for (int k = 0; k < 15; k++)
      q.push_back('{key: exp_keys[k], rnd: 4'(k), last: (k == 14)});
    rd_start = 1'b1; rd_dir = 1'b0; out_ready = 1'b1;
    tick();
    rd_start = 1'b0;
    repeat (3) tick();
    #2;
    rst = 1'b0;
    #1;
    chk("arst_valid", {127'd0, out_valid}, 128'd0);
    chk("arst_state", {126'd0, dut.state}, {126'd0, IDLE});
    chk("arst_key", out_key, 128'd0);
    q.delete();
    out_ready = 1'b0;
    tick();
    rst = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
